// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes and the bus FSM states.
package mem_pkg;

   localparam logic [1:0] BYTE      = 2'b00;
   localparam logic [1:0] HALF_WORD = 2'b01;
   localparam logic [1:0] WORD      = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store replication/enables, load lane extraction and extension.
module mem_lane_fmt
   import mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_unsigned,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_load_word,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_load_data,
   output logic        o_misaligned
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = i_load_word[{i_off, 3'b000} +: 8];
      lane_h = i_load_word[{i_off[1], 4'b0000} +: 16];
      // size 2'b10 falls into the word branches on purpose
      o_misaligned = ((i_size == HALF_WORD) & i_off[0]) | (i_size[1] & (i_off != 2'b00));
      case (i_size)
         BYTE: begin
            o_wdata     = {4{i_store_data[7:0]}};
            o_be        = 4'b0001 << i_off;
            o_load_data = i_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         end
         HALF_WORD: begin
            o_wdata     = {2{i_store_data[15:0]}};
            o_be        = 4'b0011 << i_off;
            o_load_data = i_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
         end
         default: begin
            o_wdata     = i_store_data;
            o_be        = 4'b1111;
            o_load_data = i_load_word;
         end
      endcase
   end

endmodule

// File: rtl/etapa_mem_hs.sv
// MIPS MEM stage with a req/ack data-memory bus, fault flags and a hazard stall.
module etapa_mem_hs
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH     = 12,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MAX_WAIT       = 255,
   parameter int WAIT_CNT_WIDTH = 8
)(
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic                      i_valid,
   input  logic [REG_ADDR_WIDTH-1:0] i_write_reg,
   input  logic [31:0]               i_data_to_write_in_MEM,
   input  logic [31:0]               i_ALU_result,
   input  logic                      i_WB_write,
   input  logic                      i_WB_mem_to_reg,
   input  logic                      i_MEM_read,
   input  logic                      i_MEM_write,
   input  logic                      i_MEM_unsigned,
   input  logic [1:0]                i_MEM_byte_half_word,
   output logic                      o_stall,
   output logic                      o_valid,
   output logic                      o_WB_write,
   output logic                      o_WB_mem_to_reg,
   output logic [31:0]               o_ALU_result,
   output logic [31:0]               o_read_data,
   output logic [REG_ADDR_WIDTH-1:0] o_write_reg,
   output logic                      o_misaligned,
   output logic                      o_bus_timeout,
   output logic                      o_mem_req,
   output logic                      o_mem_we,
   output logic [ADDR_WIDTH-1:0]     o_mem_addr,
   output logic [31:0]               o_mem_wdata,
   output logic [3:0]                o_mem_be,
   input  logic                      i_mem_ack,
   input  logic [31:0]               i_mem_rdata
);

   localparam logic [WAIT_CNT_WIDTH-1:0] CNT_LAST = WAIT_CNT_WIDTH'(MAX_WAIT - 1);

   state_t                    state_q, state_d;
   logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;

   // instruction context captured when the bus request is launched
   logic [REG_ADDR_WIDTH-1:0] lat_wreg_q, lat_wreg_d;
   logic [31:0]               lat_alu_q, lat_alu_d;
   logic                      lat_wb_q, lat_wb_d;
   logic                      lat_m2r_q, lat_m2r_d;
   logic                      lat_load_q, lat_load_d;
   logic                      lat_uns_q, lat_uns_d;
   logic [1:0]                lat_size_q, lat_size_d;
   logic [1:0]                lat_off_q, lat_off_d;

   logic                      valid_q, valid_d;
   logic                      wb_q, wb_d;
   logic                      m2r_q, m2r_d;
   logic [31:0]               alu_q, alu_d;
   logic [31:0]               rdata_q, rdata_d;
   logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;
   logic                      mis_q, mis_d;
   logic                      tmo_q, tmo_d;
   logic                      req_q, req_d;
   logic                      we_q, we_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [31:0]               wdata_q, wdata_d;
   logic [3:0]                be_q, be_d;

   logic        memop, in_req;
   logic [1:0]  fmt_size, fmt_off;
   logic        fmt_uns, fmt_mis;
   logic [31:0] fmt_wdata, fmt_load;
   logic [3:0]  fmt_be;

   assign memop    = i_valid & (i_MEM_read | i_MEM_write);
   assign in_req   = (state_q == REQ);
   assign fmt_size = in_req ? lat_size_q : i_MEM_byte_half_word;
   assign fmt_off  = in_req ? lat_off_q  : i_ALU_result[1:0];
   assign fmt_uns  = in_req ? lat_uns_q  : i_MEM_unsigned;

   mem_lane_fmt u_fmt (
      .i_size       (fmt_size),
      .i_off        (fmt_off),
      .i_unsigned   (fmt_uns),
      .i_store_data (i_data_to_write_in_MEM),
      .i_load_word  (i_mem_rdata),
      .o_wdata      (fmt_wdata),
      .o_be         (fmt_be),
      .o_load_data  (fmt_load),
      .o_misaligned (fmt_mis)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      o_stall    = 1'b0;
      lat_wreg_d = lat_wreg_q;
      lat_alu_d  = lat_alu_q;
      lat_wb_d   = lat_wb_q;
      lat_m2r_d  = lat_m2r_q;
      lat_load_d = lat_load_q;
      lat_uns_d  = lat_uns_q;
      lat_size_d = lat_size_q;
      lat_off_d  = lat_off_q;
      valid_d    = 1'b0;
      wb_d       = 1'b0;
      m2r_d      = m2r_q;
      alu_d      = alu_q;
      rdata_d    = 32'h0;
      wreg_d     = wreg_q;
      mis_d      = 1'b0;
      tmo_d      = 1'b0;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      case (state_q)
         IDLE: begin
            if (memop & ~fmt_mis) begin
               o_stall    = 1'b1;
               state_d    = REQ;
               cnt_d      = '0;
               req_d      = 1'b1;
               we_d       = i_MEM_write;
               addr_d     = {i_ALU_result[ADDR_WIDTH-1:2], 2'b00};
               wdata_d    = fmt_wdata;
               be_d       = fmt_be;
               lat_wreg_d = i_write_reg;
               lat_alu_d  = i_ALU_result;
               lat_wb_d   = i_WB_write;
               lat_m2r_d  = i_WB_mem_to_reg;
               lat_load_d = i_MEM_read & ~i_MEM_write;
               lat_uns_d  = i_MEM_unsigned;
               lat_size_d = i_MEM_byte_half_word;
               lat_off_d  = i_ALU_result[1:0];
            end else begin
               valid_d = i_valid;
               wb_d    = i_valid & i_WB_write & ~memop;
               m2r_d   = i_WB_mem_to_reg;
               alu_d   = i_ALU_result;
               wreg_d  = i_write_reg;
               mis_d   = memop;
            end
         end
         REQ: begin
            o_stall = ~i_mem_ack & (cnt_q != CNT_LAST);
            if (i_mem_ack | (cnt_q == CNT_LAST)) begin
               // ack takes priority over a timeout landing in the same cycle
               state_d = IDLE;
               req_d   = 1'b0;
               valid_d = 1'b1;
               m2r_d   = lat_m2r_q;
               alu_d   = lat_alu_q;
               wreg_d  = lat_wreg_q;
               wb_d    = i_mem_ack & lat_wb_q;
               tmo_d   = ~i_mem_ack;
               rdata_d = (i_mem_ack & lat_load_q) ? fmt_load : 32'h0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         lat_wreg_q <= '0;
         lat_alu_q  <= '0;
         lat_wb_q   <= 1'b0;
         lat_m2r_q  <= 1'b0;
         lat_load_q <= 1'b0;
         lat_uns_q  <= 1'b0;
         lat_size_q <= '0;
         lat_off_q  <= '0;
         valid_q    <= 1'b0;
         wb_q       <= 1'b0;
         m2r_q      <= 1'b0;
         alu_q      <= '0;
         rdata_q    <= '0;
         wreg_q     <= '0;
         mis_q      <= 1'b0;
         tmo_q      <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_wreg_q <= lat_wreg_d;
         lat_alu_q  <= lat_alu_d;
         lat_wb_q   <= lat_wb_d;
         lat_m2r_q  <= lat_m2r_d;
         lat_load_q <= lat_load_d;
         lat_uns_q  <= lat_uns_d;
         lat_size_q <= lat_size_d;
         lat_off_q  <= lat_off_d;
         valid_q    <= valid_d;
         wb_q       <= wb_d;
         m2r_q      <= m2r_d;
         alu_q      <= alu_d;
         rdata_q    <= rdata_d;
         wreg_q     <= wreg_d;
         mis_q      <= mis_d;
         tmo_q      <= tmo_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
      end
   end

   assign o_valid         = valid_q;
   assign o_WB_write      = wb_q;
   assign o_WB_mem_to_reg = m2r_q;
   assign o_ALU_result    = alu_q;
   assign o_read_data     = rdata_q;
   assign o_write_reg     = wreg_q;
   assign o_misaligned    = mis_q;
   assign o_bus_timeout   = tmo_q;
   assign o_mem_req       = req_q;
   assign o_mem_we        = we_q;
   assign o_mem_addr      = addr_q;
   assign o_mem_wdata     = wdata_q;
   assign o_mem_be        = be_q;

endmodule

// File: tb/tb_etapa_mem_hs.sv
// Self-checking bench for etapa_mem_hs: vector table driven through a scoreboard plus reset corner case.
module tb_etapa_mem_hs;

   localparam int NO_ACK = 99;
   localparam int NV     = 14;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_valid;
   logic [4:0]  i_write_reg;
   logic [31:0] i_data_to_write_in_MEM;
   logic [31:0] i_ALU_result;
   logic        i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned;
   logic [1:0]  i_MEM_byte_half_word;
   logic        o_stall, o_valid, o_WB_write, o_WB_mem_to_reg;
   logic [31:0] o_ALU_result, o_read_data;
   logic [4:0]  o_write_reg;
   logic        o_misaligned, o_bus_timeout, o_mem_req, o_mem_we;
   logic [11:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   always #5 i_clk = ~i_clk;

   etapa_mem_hs #(.ADDR_WIDTH(12), .REG_ADDR_WIDTH(5), .MAX_WAIT(4), .WAIT_CNT_WIDTH(8)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_write_reg(i_write_reg),
      .i_data_to_write_in_MEM(i_data_to_write_in_MEM), .i_ALU_result(i_ALU_result),
      .i_WB_write(i_WB_write), .i_WB_mem_to_reg(i_WB_mem_to_reg), .i_MEM_read(i_MEM_read),
      .i_MEM_write(i_MEM_write), .i_MEM_unsigned(i_MEM_unsigned),
      .i_MEM_byte_half_word(i_MEM_byte_half_word), .o_stall(o_stall), .o_valid(o_valid),
      .o_WB_write(o_WB_write), .o_WB_mem_to_reg(o_WB_mem_to_reg), .o_ALU_result(o_ALU_result),
      .o_read_data(o_read_data), .o_write_reg(o_write_reg), .o_misaligned(o_misaligned),
      .o_bus_timeout(o_bus_timeout), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
      .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
   );

   typedef struct {
      logic        valid, rd, wr, uns;
      logic [1:0]  sz;
      logic [31:0] alu, din, rdata;
      int          ack_dly;
      logic        wb;
      logic [4:0]  wreg;
      logic [31:0] exp_rd;
      logic [11:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic        exp_wb, exp_mis, exp_tmo;
      int          exp_stall;
      logic        exp_req;
   } vec_t;

   vec_t vecs[NV];
   vec_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      i_valid = 1'b0; i_MEM_read = 1'b0; i_MEM_write = 1'b0;
   endtask

   // caller is positioned 1 time unit after a rising edge
   task automatic do_op(input vec_t v, input int idx);
      vec_t e;
      int   stalls = 0, reqc = 0, cyc = 0;
      bit   got = 1'b0, req_seen = 1'b0, st;
      string tag;
      tag = $sformatf("v%0d", idx);
      sb.push_back(v);
      i_valid = v.valid; i_MEM_read = v.rd; i_MEM_write = v.wr; i_MEM_unsigned = v.uns;
      i_MEM_byte_half_word = v.sz; i_ALU_result = v.alu; i_data_to_write_in_MEM = v.din;
      i_WB_write = v.wb; i_WB_mem_to_reg = v.rd; i_write_reg = v.wreg;
      while (!got && cyc < 40) begin
         if (o_mem_req) begin
            if (!req_seen) begin
               req_seen = 1'b1;
               chk({tag, "_addr"}, 32'(o_mem_addr), 32'(v.exp_addr));
               chk({tag, "_we"}, 32'(o_mem_we), 32'(v.wr));
               if (v.wr) begin
                  chk({tag, "_be"}, 32'(o_mem_be), 32'(v.exp_be));
                  chk({tag, "_wdata"}, o_mem_wdata, v.exp_wd);
               end
            end
            if (reqc == v.ack_dly) begin
               i_mem_ack = 1'b1; i_mem_rdata = v.rdata;
            end
            reqc++;
         end
         #1;
         st = o_stall;
         if (st) stalls++;
         @(posedge i_clk); #1;
         i_mem_ack = 1'b0; i_mem_rdata = 32'h5A5A5A5A;
         if (!st) drive_idle();
         if (o_valid) begin
            got = 1'b1;
            if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            else begin
               e = sb.pop_front();
               chk({tag, "_rdata"}, o_read_data, e.exp_rd);
               chk({tag, "_wb"}, 32'(o_WB_write), 32'(e.exp_wb));
               chk({tag, "_alu"}, o_ALU_result, e.alu);
               chk({tag, "_wreg"}, 32'(o_write_reg), 32'(e.wreg));
               chk({tag, "_mis"}, 32'(o_misaligned), 32'(e.exp_mis));
               chk({tag, "_tmo"}, 32'(o_bus_timeout), 32'(e.exp_tmo));
               chk({tag, "_req_done"}, 32'(o_mem_req), 32'd0);
            end
         end
         cyc++;
      end
      if (!got) chk({tag, "_no_result"}, 32'd0, 32'd1);
      chk({tag, "_stalls"}, 32'(stalls), 32'(v.exp_stall));
      chk({tag, "_req_seen"}, 32'(req_seen), 32'(v.exp_req));
      // following cycle: flags gone; a late ack after a timeout must be ignored
      if (v.exp_tmo) begin i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF; end
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
      chk({tag, "_post_valid"}, 32'(o_valid), 32'd0);
      chk({tag, "_post_flags"}, {30'd0, o_misaligned, o_bus_timeout}, 32'd0);
      chk({tag, "_post_req"}, 32'(o_mem_req), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   k;
      //          vld rd wr un sz     alu           din           rdata        dly     wb wreg exp_rd        addr    be    wd            wb mis tmo stl req
      vecs[0]  = '{1, 0, 0, 0, 2'b11, 32'h00001234, 32'h0,        32'h0,        0,      1, 3,  32'h0,        12'h000, 4'h0, 32'h0,        1, 0, 0, 0, 0};
      vecs[1]  = '{1, 0, 1, 0, 2'b00, 32'h00000003, 32'h000000A5, 32'h0,        2,      0, 0,  32'h0,        12'h000, 4'h8, 32'hA5A5A5A5, 0, 0, 0, 3, 1};
      vecs[2]  = '{1, 1, 0, 0, 2'b01, 32'h00000006, 32'h0,        32'h80017FFF, 0,      1, 8,  32'hFFFF8001, 12'h004, 4'h0, 32'h0,        1, 0, 0, 1, 1};
      vecs[3]  = '{1, 1, 0, 1, 2'b01, 32'h00000006, 32'h0,        32'h80017FFF, 0,      1, 8,  32'h00008001, 12'h004, 4'h0, 32'h0,        1, 0, 0, 1, 1};
      vecs[4]  = '{1, 1, 0, 0, 2'b00, 32'h00000004, 32'h0,        32'h00000080, 0,      1, 9,  32'hFFFFFF80, 12'h004, 4'h0, 32'h0,        1, 0, 0, 1, 1};
      vecs[5]  = '{1, 1, 0, 0, 2'b11, 32'h00000002, 32'h0,        32'h0,        0,      1, 10, 32'h0,        12'h000, 4'h0, 32'h0,        0, 1, 0, 0, 0};
      vecs[6]  = '{1, 1, 0, 0, 2'b11, 32'h00000010, 32'h0,        32'h0,        NO_ACK, 1, 11, 32'h0,        12'h010, 4'h0, 32'h0,        0, 0, 1, 4, 1};
      vecs[7]  = '{1, 0, 1, 0, 2'b01, 32'h00000102, 32'h0000BEEF, 32'h0,        1,      0, 0,  32'h0,        12'h100, 4'hC, 32'hBEEFBEEF, 0, 0, 0, 2, 1};
      vecs[8]  = '{1, 1, 0, 1, 2'b00, 32'h00000007, 32'h0,        32'hAB000000, 3,      1, 12, 32'h000000AB, 12'h004, 4'h0, 32'h0,        1, 0, 0, 4, 1};
      vecs[9]  = '{1, 0, 1, 0, 2'b11, 32'h00000008, 32'h12345678, 32'h0,        0,      0, 0,  32'h0,        12'h008, 4'hF, 32'h12345678, 0, 0, 0, 1, 1};
      vecs[10] = '{1, 1, 1, 0, 2'b11, 32'h0000000C, 32'hCAFEF00D, 32'hFFFFFFFF, 0,      0, 0,  32'h0,        12'h00C, 4'hF, 32'hCAFEF00D, 0, 0, 0, 1, 1};
      vecs[11] = '{1, 0, 1, 0, 2'b01, 32'h00000001, 32'h00001111, 32'h0,        0,      0, 0,  32'h0,        12'h000, 4'h0, 32'h0,        0, 1, 0, 0, 0};
      vecs[12] = '{1, 1, 0, 1, 2'b01, 32'h00000000, 32'h0,        32'h1234F00F, 0,      1, 13, 32'h0000F00F, 12'h000, 4'h0, 32'h0,        1, 0, 0, 1, 1};
      vecs[13] = '{1, 1, 0, 0, 2'b11, 32'h00000FFC, 32'h0,        32'h76543210, 0,      1, 14, 32'h76543210, 12'hFFC, 4'h0, 32'h0,        1, 0, 0, 1, 1};

      i_reset_n = 1'b0; drive_idle(); i_MEM_unsigned = 1'b0; i_MEM_byte_half_word = 2'b11;
      i_write_reg = '0; i_data_to_write_in_MEM = '0; i_ALU_result = '0;
      i_WB_write = 1'b0; i_WB_mem_to_reg = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_req", 32'(o_mem_req), 32'd0);
      chk("rst_stall", 32'(o_stall), 32'd0);
      chk("rst_alu", o_ALU_result, 32'd0);
      i_reset_n = 1'b1;

      for (int i = 0; i < NV; i++) do_op(vecs[i], i);

      // reset while a request is outstanding
      i_valid = 1'b1; i_MEM_read = 1'b1; i_MEM_write = 1'b0; i_MEM_byte_half_word = 2'b11;
      i_ALU_result = 32'h20; i_WB_write = 1'b1; i_write_reg = 5'd7;
      k = 0;
      while (!o_mem_req && k < 10) begin
         @(posedge i_clk); #1; k++;
      end
      chk("rst_mid_req_up", 32'(o_mem_req), 32'd1);
      i_reset_n = 1'b0; drive_idle();
      @(posedge i_clk); #1;
      chk("rst_mid_req", 32'(o_mem_req), 32'd0);
      chk("rst_mid_addr", 32'(o_mem_addr), 32'd0);
      chk("rst_mid_valid", 32'(o_valid), 32'd0);
      chk("rst_mid_stall", 32'(o_stall), 32'd0);
      i_reset_n = 1'b1;
      i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
      chk("rst_late_ack_valid", 32'(o_valid), 32'd0);
      chk("rst_late_ack_req", 32'(o_mem_req), 32'd0);
      v = '{1, 1, 0, 0, 2'b11, 32'h0, 32'h0, 32'hDEADBEEF, 1, 1, 5'd2, 32'hDEADBEEF, 12'h000, 4'h0, 32'h0, 1, 0, 0, 2, 1};
      do_op(v, 99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
